// File: rtl/fpu_req_issuer.sv
// fpu_req_issuer: core-side initiator of the FPU valid/result handshake.
// Optional abort-on-timeout in BUSY: define FPU_ISSUE_TIMEOUT_EN.
module fpu_req_issuer #(
    parameter int OP_W           = 3,
    parameter int RD_W           = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [OP_W-1:0] req_op,
    input  logic [RD_W-1:0] req_rd,
    output logic            data_valid,
    output logic [31:0]     a_data,
    output logic [31:0]     b_data,
    output logic [OP_W-1:0] op_data,
    input  logic [31:0]     c_data,
    input  logic            c_valid,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [RD_W-1:0] rd_q;
    logic            accept;
    logic            done_ok;
    logic            done_to;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..255");
    end

    // Ready is masked while reset is held so the core never sees it early.
    assign req_ready  = (state == S_IDLE) && !aresetn;
    assign data_valid = (state == S_BUSY);
    assign accept     = (state == S_IDLE) && req_valid;
    assign done_ok    = (state == S_BUSY) && c_valid;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;
    logic       err_q;

    // Cycles spent in BUSY; cleared on entry, saturating.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            cnt <= 8'd0;
        end else if (accept) begin
            cnt <= 8'd0;
        end else if (state == S_BUSY && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // A real result on the abort edge takes priority over the abort.
    assign done_to = (state == S_BUSY) && !c_valid && (cnt == TO_LAST);

    // Sticky record that some op was aborted.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            err_q <= 1'b0;
        end else if (done_to) begin
            err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign done_to     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: one op in flight, then a single settle cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (done_ok || done_to) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request capture; held stable to the FPU for the whole BUSY phase.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            a_data  <= 32'd0;
            b_data  <= 32'd0;
            op_data <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            a_data  <= req_a;
            b_data  <= req_b;
            op_data <= req_op;
            rd_q    <= req_rd;
        end
    end

    // Writeback pulse; data and rd hold between pulses.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= done_ok || done_to;
            if (done_ok) begin
                wb_rd   <= rd_q;
                wb_data <= c_data;
            end else if (done_to) begin
                wb_rd   <= rd_q;
                wb_data <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_req_issuer.sv
// tb_fpu_req_issuer: directed vectors for fpu_req_issuer with a
// behavioural FP compare unit answering one edge after data_valid.
module tb_fpu_req_issuer;

    localparam int OP_W = 3;
    localparam int RD_W = 5;

    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_GE = 3'd3;
    localparam logic [2:0] OP_LT = 3'd4;
    localparam logic [2:0] OP_GT = 3'd5;

    logic            aclk;
    logic            aresetn;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [OP_W-1:0] req_op;
    logic [RD_W-1:0] req_rd;
    logic            data_valid;
    logic [31:0]     a_data;
    logic [31:0]     b_data;
    logic [OP_W-1:0] op_data;
    logic [31:0]     c_data;
    logic            c_valid;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            err_timeout;

    logic            fpu_en;
    logic            c_spur;
    logic            cv_m;

    int checks = 0;
    int passed = 0;

    fpu_req_issuer #(
        .OP_W(OP_W),
        .RD_W(RD_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .req_rd(req_rd),
        .data_valid(data_valid),
        .a_data(a_data),
        .b_data(b_data),
        .op_data(op_data),
        .c_data(c_data),
        .c_valid(c_valid),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .err_timeout(err_timeout)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic fcmp(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [2:0]  op);
        logic        nan;
        logic        eq;
        logic        lt;
        logic [31:0] ka;
        logic [31:0] kb;
        nan = (a[30:23] == 8'hFF && a[22:0] != 23'd0) ||
              (b[30:23] == 8'hFF && b[22:0] != 23'd0);
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) begin
            eq = 1'b1;
            lt = 1'b0;
        end else begin
            eq = (a == b);
            lt = (ka < kb);
        end
        case (op)
            3'd0:    fcmp = eq && !nan;
            3'd1:    fcmp = !eq || nan;
            3'd2:    fcmp = (lt || eq) && !nan;
            3'd3:    fcmp = !lt && !nan;
            3'd4:    fcmp = lt && !nan;
            3'd5:    fcmp = !lt && !eq && !nan;
            default: fcmp = 1'b0;
        endcase
    endfunction

    // Compare unit: result one edge after it sees data_valid, cleared when it drops.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            cv_m   <= 1'b0;
            c_data <= 32'd0;
        end else begin
            cv_m   <= fpu_en && data_valid;
            c_data <= {31'd0, fcmp(a_data, b_data, op_data)};
        end
    end

    assign c_valid = cv_m | c_spur;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 16; i++) begin
            if (req_ready) break;
            @(negedge aclk);
        end
        chk("ready_wait", req_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready();
        req_valid = 1'b1;
        req_a     = v.a;
        req_b     = v.b;
        req_op    = v.op;
        req_rd    = v.rd;
        @(negedge aclk);
        req_valid = 1'b0;
        chk("dv_after_accept", data_valid, 1'b1);
        chk("a_data", a_data, v.a);
        chk("b_data", b_data, v.b);
        chk("op_data", {29'd0, op_data}, {29'd0, v.op});
        @(negedge aclk);
        chk("wb_early", wb_valid, 1'b0);
        @(negedge aclk);
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        chk("wb_data", wb_data, v.exp);
        chk("dv_drop", data_valid, 1'b0);
        chk("gap_ready", req_ready, 1'b0);
        @(negedge aclk);
        chk("wb_pulse", wb_valid, 1'b0);
        chk("wb_hold", wb_data, v.exp);
        chk("ready_idle", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int wbn;
        int rises;
        int bad;
        int n;
        int acc_k[8];
        logic prev_dv;
        logic [31:0] hold_a;
        logic [31:0] hold_b;

        vt[0] = '{OP_LT, 32'h3F80_0000, 32'h4000_0000, 5'd7, 32'd1};
        vt[1] = '{OP_EQ, 32'h8000_0000, 32'h0000_0000, 5'd3, 32'd1};
        vt[2] = '{OP_NE, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'd0};
        vt[3] = '{OP_GT, 32'h4000_0000, 32'h3F80_0000, 5'd1, 32'd1};
        vt[4] = '{OP_LE, 32'h4000_0000, 32'h3F80_0000, 5'd2, 32'd0};
        vt[5] = '{OP_GE, 32'h3F80_0000, 32'h3F80_0000, 5'd5, 32'd1};
        vt[6] = '{OP_LT, 32'hBF80_0000, 32'h3F80_0000, 5'd6, 32'd1};
        vt[7] = '{OP_GT, 32'hC000_0000, 32'hBF80_0000, 5'd8, 32'd0};
        vt[8] = '{OP_EQ, 32'h7FC0_0000, 32'h7FC0_0000, 5'd9, 32'd0};
        vt[9] = '{OP_NE, 32'h7FC0_0000, 32'h7FC0_0000, 5'd10, 32'd1};

        aresetn   = 1'b1;
        req_valid = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_op    = '0;
        req_rd    = '0;
        fpu_en    = 1'b1;
        c_spur    = 1'b0;

        repeat (2) @(negedge aclk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_wb", wb_valid, 1'b0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_err", err_timeout, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
        end

        wait_ready();
        acc     = 0;
        wbn     = 0;
        rises   = 0;
        bad     = 0;
        prev_dv = 1'b0;
        hold_a  = 32'd0;
        hold_b  = 32'd0;
        req_valid = 1'b1;
        req_b     = 32'h3F80_0000;
        req_op    = OP_GT;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin
                if (acc < 8) acc_k[acc] = k;
                acc++;
            end
            req_a  = 32'h4000_0000 + 32'(k);
            req_rd = 5'(k);
            @(negedge aclk);
            if (wb_valid) begin
                wbn++;
                if (wb_data != 32'd1) bad++;
            end
            if (data_valid) begin
                if (!prev_dv) begin
                    rises++;
                    hold_a = a_data;
                    hold_b = b_data;
                end else if (a_data != hold_a || b_data != hold_b ||
                             op_data != OP_GT) begin
                    bad++;
                end
            end
            prev_dv = data_valid;
        end
        req_valid = 1'b0;
        chk("stream_accepts", acc, 5);
        chk("stream_wb", wbn, 5);
        chk("stream_dv_rises", rises, 5);
        chk("stream_hold", bad, 0);
        n = 0;
        for (int i = 1; i < 5 && i < acc; i++) begin
            if (acc_k[i] - acc_k[i-1] != 4) n++;
        end
        chk("stream_interval", n, 0);

        wait_ready();
        req_valid = 1'b1;
        req_a     = 32'h3F80_0000;
        req_b     = 32'h4000_0000;
        req_op    = OP_LT;
        req_rd    = 5'd12;
        @(negedge aclk);
        req_valid = 1'b0;
        aresetn   = 1'b1;
        #1;
        chk("midrst_dv", data_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("midrst_ready_after", req_ready, 1'b1);
        n = 0;
        repeat (4) begin
            @(negedge aclk);
            if (wb_valid || data_valid) n++;
        end
        chk("midrst_no_wb", n, 0);

        fpu_en = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_a     = 32'h4000_0000;
        req_b     = 32'h3F80_0000;
        req_op    = OP_GT;
        req_rd    = 5'd11;
`ifdef FPU_ISSUE_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge aclk);
            req_valid = 1'b0;
            if (wb_valid) begin
                n = i;
                break;
            end
        end
        chk("to_latency", n, 9);
        chk("to_wbdata", wb_data, 32'd0);
        chk("to_wbrd", {27'd0, wb_rd}, 32'd11);
        chk("to_err", err_timeout, 1'b1);
        fpu_en = 1'b1;
        @(negedge aclk);
        chk("to_err_sticky", err_timeout, 1'b1);
        run_vec(vt[0]);
        chk("to_err_after_op", err_timeout, 1'b1);
`else
        n = 0;
        repeat (20) begin
            @(negedge aclk);
            req_valid = 1'b0;
            if (wb_valid) n++;
        end
        chk("wait_no_wb", n, 0);
        chk("wait_dv", data_valid, 1'b1);
        chk("wait_err", err_timeout, 1'b0);
        fpu_en = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge aclk);
            if (wb_valid) begin
                n = i;
                break;
            end
        end
        chk("late_latency", n, 2);
        chk("late_wbdata", wb_data, 32'd1);
        chk("late_wbrd", {27'd0, wb_rd}, 32'd11);
        chk("late_err", err_timeout, 1'b0);
`endif

        wait_ready();
        c_spur = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge aclk);
            if (wb_valid || !req_ready) n++;
        end
        c_spur = 1'b0;
        @(negedge aclk);
        if (wb_valid) n++;
        chk("spurious_ignored", n, 0);
        run_vec(vt[3]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
